// File: rtl/l1_d_data_array_burst.sv
// L1 D-cache data array: WAY x 2^INUM lines in one single-port synchronous RAM.
// Handles CPU word reads and byte-masked writes, L2 burst refills and burst evictions.
module l1_d_data_array_burst #(
  parameter int INUM      = 2,
  parameter int WAY       = 2,
  parameter int LINE_BITS = 512,
  parameter int WORD_BITS = 32,
  parameter int BEAT_BITS = 128,
  localparam int WB = $clog2(WAY),
  localparam int OB = $clog2(LINE_BITS/8)
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [INUM-1:0]        req_index,
  input  logic [WB-1:0]          req_way,
  input  logic [OB-1:0]          req_offset,
  input  logic [WORD_BITS-1:0]   req_wdata,
  input  logic [WORD_BITS/8-1:0] req_be,
  output logic                   rsp_valid,
  output logic [WORD_BITS-1:0]   rsp_rdata,
  input  logic                   fill_valid,
  output logic                   fill_ready,
  input  logic [BEAT_BITS-1:0]   fill_data,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [BEAT_BITS-1:0]   wb_data,
  output logic                   wb_last,
  output logic [2:0]             dbg_state
);

  localparam int BEATS = LINE_BITS / BEAT_BITS;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WOB   = $clog2(WORD_BITS/8);
  localparam int WIB   = OB - WOB;
  localparam int AW    = INUM + WB;
  localparam int DEPTH = 1 << AW;
  localparam logic [WB:0]    WAY_L     = (WB+1)'(WAY);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS-1);

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RF = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RSP, S_MERGE, S_EVICT, S_FILL, S_FWR
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             op_q;
  logic [INUM-1:0]        idx_q;
  logic [WB-1:0]          way_q;
  logic [WIB-1:0]         woff_q;
  logic [WORD_BITS-1:0]   wdata_q;
  logic [WORD_BITS/8-1:0] be_q;
  logic                   bad_q;
  logic [BCW-1:0]         beat_q, beat_d;
  logic [LINE_BITS-1:0]   fbuf_q, fbuf_d;

  logic [LINE_BITS-1:0]   mem [DEPTH];
  logic [LINE_BITS-1:0]   rd_q;
  logic                   mem_re, mem_we;
  logic [LINE_BITS-1:0]   mem_wdata, merged_line;
  logic [WORD_BITS-1:0]   cur_word, merged_word;
  logic [AW-1:0]          addr;
  logic                   accept, req_bad;
  logic                   unused_off;

  assign accept     = req_valid && (state_q == S_IDLE);
  assign req_bad    = ({1'b0, req_way} >= WAY_L);
  assign addr       = {idx_q, way_q};
  assign dbg_state  = state_q;
  assign unused_off = ^req_offset[WOB-1:0];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      fbuf_q  <= '0;
      op_q    <= '0;
      idx_q   <= '0;
      way_q   <= '0;
      woff_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      fbuf_q  <= fbuf_d;
      if (accept) begin
        op_q    <= req_op;
        idx_q   <= req_index;
        way_q   <= req_way;
        woff_q  <= req_offset[OB-1:WOB];
        wdata_q <= req_wdata;
        be_q    <= req_be;
        bad_q   <= req_bad;
      end
    end
  end

  // Array storage has no reset; read and write never coincide since one op is in flight.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr] <= mem_wdata;
    else if (mem_re) rd_q <= mem[addr];
  end

  always_comb begin
    cur_word    = rd_q[int'(woff_q)*WORD_BITS +: WORD_BITS];
    merged_word = cur_word;
    for (int b = 0; b < WORD_BITS/8; b++) begin
      if (be_q[b]) merged_word[b*8 +: 8] = wdata_q[b*8 +: 8];
    end
    merged_line = rd_q;
    merged_line[int'(woff_q)*WORD_BITS +: WORD_BITS] = merged_word;
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    fbuf_d     = fbuf_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_rdata  = '0;
    fill_ready = 1'b0;
    wb_valid   = 1'b0;
    wb_data    = '0;
    wb_last    = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = merged_line;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        beat_d    = '0;
        if (req_valid) state_d = (req_op == OP_RF && !req_bad) ? S_FILL : S_RD;
      end
      S_RD: begin
        mem_re = 1'b1;
        // Out-of-range ways and refills only reach RD when they must complete empty-handed.
        if (bad_q || op_q == OP_RD || op_q == OP_RF) state_d = S_RSP;
        else if (op_q == OP_WR)                      state_d = S_MERGE;
        else                                         state_d = S_EVICT;
      end
      S_RSP: begin
        rsp_valid = 1'b1;
        rsp_rdata = (bad_q || op_q != OP_RD) ? '0 : cur_word;
        state_d   = S_IDLE;
      end
      S_MERGE: begin
        mem_we    = 1'b1;
        mem_wdata = merged_line;
        rsp_valid = 1'b1;
        rsp_rdata = merged_word;
        state_d   = S_IDLE;
      end
      S_EVICT: begin
        wb_valid = 1'b1;
        wb_data  = rd_q[int'(beat_q)*BEAT_BITS +: BEAT_BITS];
        wb_last  = (beat_q == LAST_BEAT);
        if (wb_ready) begin
          if (beat_q == LAST_BEAT) begin
            rsp_valid = 1'b1;
            beat_d    = '0;
            state_d   = S_IDLE;
          end else begin
            beat_d = beat_q + BCW'(1);
          end
        end
      end
      S_FILL: begin
        fill_ready = 1'b1;
        if (fill_valid) begin
          fbuf_d[int'(beat_q)*BEAT_BITS +: BEAT_BITS] = fill_data;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = S_FWR;
          end else begin
            beat_d = beat_q + BCW'(1);
          end
        end
      end
      S_FWR: begin
        mem_we    = 1'b1;
        mem_wdata = fbuf_q;
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
